// File: rtl/eth_rx_buf_pkg.sv
// Shared definitions for the receive frame buffer.
// Holds the bus register offsets, the descriptor field layout helpers,
// the receive FSM state encoding and the tkeep byte counter.
package eth_rx_buf_pkg;

  // Register offsets (bus_addr[1:0] when the register space is selected)
  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_DESC   = 2'd1;
  localparam logic [1:0] REG_POP    = 2'd2;
  localparam logic [1:0] REG_CLR    = 2'd3;

  localparam int BEAT_BYTES = 4;
  localparam int DROP_CNT_W = 16;

  // Descriptor layout, MSB to LSB: {start, words, len}
  function automatic int desc_start_w(input int addr_w);
    return addr_w;
  endfunction

  function automatic int desc_words_w(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int desc_width(input int addr_w, input int len_w);
    return desc_start_w(addr_w) + desc_words_w(addr_w) + len_w;
  endfunction

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_RECV = 2'd1,
    RX_DROP = 2'd2
  } rx_state_e;

  // Number of valid bytes on a beat; tkeep=0 counts as zero bytes.
  function automatic logic [2:0] keep_popcount(input logic [3:0] keep);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, keep[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/eth_rx_desc_fifo.sv
// First-word-fall-through descriptor FIFO.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data (ignored when full)
//   push_data  : descriptor to store
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry, valid whenever empty=0
//   count      : number of stored entries (0 .. 2^DEPTH_W)
//   full/empty : occupancy flags derived from count
module eth_rx_desc_fifo #(
  parameter int WIDTH   = 32,
  parameter int DEPTH_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   head,
  output logic [DEPTH_W:0]   count,
  output logic               full,
  output logic               empty
);

  localparam logic [DEPTH_W:0]   DEPTH   = (DEPTH_W+1)'(1 << DEPTH_W);
  localparam logic [DEPTH_W-1:0] IDX_ONE = DEPTH_W'(1);
  localparam logic [DEPTH_W:0]   CNT_ONE = (DEPTH_W+1)'(1);

  logic [WIDTH-1:0]   mem [1 << DEPTH_W];
  logic [DEPTH_W-1:0] wr_idx;
  logic [DEPTH_W-1:0] rd_idx;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_idx <= wr_idx + IDX_ONE;
      if (do_pop)  rd_idx <= rd_idx + IDX_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/eth_rx_frame_buffer.sv
// Store-and-forward receive buffer behind the MAC receive stream.
// Good frames land in a circular packet RAM with one descriptor each;
// bad, oversized or non-fitting frames are discarded by rolling wr_ptr
// back to the frame start. Firmware reads RAM and registers over a
// word-addressed bus.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   s_axis_*          : receive stream. A beat transfers when tvalid and
//                       tready are both 1 on a rising edge; tready is 0 in
//                       reset and 1 ever after (no backpressure).
//   bus_valid/we/addr : bus request, sampled on a rising edge; bus_addr[ADDR_W]
//                       selects registers (1) or packet RAM (0)
//   bus_wdata         : write data (register writes act on address alone)
//   bus_rdata         : read data, valid while bus_ready=1
//   bus_ready         : one-cycle pulse the cycle after a sampled request
//   frame_avail       : at least one committed frame is waiting
//
// The FSM state is kept in rx_state for observation.
module eth_rx_frame_buffer
  import eth_rx_buf_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DESC_DEPTH_W = 4,
  parameter int LEN_W        = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       s_axis_tdata,
  input  logic [3:0]        s_axis_tkeep,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tuser,
  input  logic              bus_valid,
  input  logic              bus_we,
  input  logic [ADDR_W:0]   bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_ready,
  output logic              frame_avail
);

  localparam int               DESC_W    = desc_width(ADDR_W, LEN_W);
  localparam logic [ADDR_W:0]  PTR_ONE   = (ADDR_W+1)'(1);
  localparam logic [LEN_W:0]   MAX_LEN   = {1'b0, {LEN_W{1'b1}}};
  localparam logic [LEN_W:0]   FULL_BEAT = (LEN_W+1)'(BEAT_BYTES);

  rx_state_e             rx_state;
  logic [ADDR_W:0]       wr_ptr;
  logic [ADDR_W:0]       wr_start;
  logic [ADDR_W:0]       rd_ptr;
  logic [ADDR_W:0]       used;
  logic [ADDR_W:0]       frame_start;
  logic [ADDR_W:0]       words_next;
  logic [LEN_W:0]        byte_cnt;
  logic [LEN_W:0]        cnt_base;
  logic [LEN_W:0]        cnt_next;
  logic [LEN_W:0]        beat_bytes;
  logic [DROP_CNT_W-1:0] drop_cnt;
  logic                  tready_q;

  logic accept;
  logic ram_full;
  logic len_over;
  logic overflow;
  logic take_beat;
  logic commit;
  logic drop_now;

  logic [DESC_W-1:0]     desc_push_data;
  logic [DESC_W-1:0]     desc_head;
  logic [DESC_DEPTH_W:0] desc_count;
  logic                  desc_full;
  logic                  desc_empty;
  logic                  desc_pop;
  logic [ADDR_W-1:0]     head_start;
  logic [ADDR_W:0]       head_words;
  logic [LEN_W-1:0]      head_len;

  logic        sel_reg;
  logic [1:0]  reg_off;
  logic        wr_reg;
  logic        clr_fire;
  logic [31:0] reg_rval;
  logic [31:0] reg_rdata_q;
  logic [31:0] ram_rd_q;
  logic        sel_ram_q;
  logic        bus_ready_q;
  logic        unused_wdata;

  logic [31:0] mem [1 << ADDR_W];

  assign unused_wdata  = ^bus_wdata;
  assign s_axis_tready = tready_q;
  assign bus_ready     = bus_ready_q;
  assign bus_rdata     = sel_ram_q ? ram_rd_q : reg_rdata_q;
  assign frame_avail   = !desc_empty;

  // ---------------------------------------------------------------- receive
  assign accept = s_axis_tvalid && tready_q;

  // Pointers carry one extra bit, so used can reach exactly 2^ADDR_W and
  // its top bit alone means "full".
  assign used     = wr_ptr - rd_ptr;
  assign ram_full = used[ADDR_W];

  assign beat_bytes  = s_axis_tlast ? (LEN_W+1)'(keep_popcount(s_axis_tkeep)) : FULL_BEAT;
  assign cnt_base    = (rx_state == RX_IDLE) ? '0 : byte_cnt;
  assign cnt_next    = cnt_base + beat_bytes;
  assign len_over    = cnt_next > MAX_LEN;
  assign overflow    = ram_full || len_over;
  assign frame_start = (rx_state == RX_IDLE) ? wr_ptr : wr_start;
  assign words_next  = wr_ptr + PTR_ONE - frame_start;

  // A beat is stored only while a frame is live and it fits; the IDLE
  // path also refuses to open a frame when no descriptor slot is left.
  assign take_beat = accept && !overflow &&
                     ((rx_state == RX_RECV) || (rx_state == RX_IDLE && !desc_full));
  assign commit    = take_beat && s_axis_tlast && !s_axis_tuser;
  assign drop_now  = accept && s_axis_tlast && !commit;

  assign desc_push_data = {frame_start[ADDR_W-1:0], words_next, cnt_next[LEN_W-1:0]};
  assign {head_start, head_words, head_len} = desc_head;

  always_ff @(posedge clk) begin
    if (take_beat) begin
      mem[wr_ptr[ADDR_W-1:0]] <= s_axis_tdata;
    end
    // Read-before-write: a same-address write this cycle is not visible.
    ram_rd_q <= mem[bus_addr[ADDR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      wr_ptr   <= '0;
      wr_start <= '0;
      rd_ptr   <= '0;
      byte_cnt <= '0;
      drop_cnt <= '0;
      tready_q <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      case (rx_state)
        RX_IDLE: begin
          if (accept) begin
            if (take_beat) begin
              wr_start <= wr_ptr;
              byte_cnt <= cnt_next;
              if (!s_axis_tlast) begin
                wr_ptr   <= wr_ptr + PTR_ONE;
                rx_state <= RX_RECV;
              end else if (commit) begin
                wr_ptr <= wr_ptr + PTR_ONE;
              end
            end else if (!s_axis_tlast) begin
              rx_state <= RX_DROP;
            end
          end
        end
        RX_RECV: begin
          if (accept) begin
            if (!take_beat) begin
              wr_ptr   <= wr_start;
              rx_state <= s_axis_tlast ? RX_IDLE : RX_DROP;
            end else if (s_axis_tlast) begin
              wr_ptr   <= commit ? (wr_ptr + PTR_ONE) : wr_start;
              rx_state <= RX_IDLE;
            end else begin
              wr_ptr   <= wr_ptr + PTR_ONE;
              byte_cnt <= cnt_next;
            end
          end
        end
        RX_DROP: begin
          if (accept && s_axis_tlast) begin
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase

      if (desc_pop) begin
        rd_ptr <= rd_ptr + head_words;
      end

      // One count per discarded frame, counted when its last beat passes.
      if (clr_fire) begin
        drop_cnt <= '0;
      end else if (drop_now && (drop_cnt != {DROP_CNT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

  eth_rx_desc_fifo #(
    .WIDTH   (DESC_W),
    .DEPTH_W (DESC_DEPTH_W)
  ) u_desc_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (commit),
    .push_data (desc_push_data),
    .pop       (desc_pop),
    .head      (desc_head),
    .count     (desc_count),
    .full      (desc_full),
    .empty     (desc_empty)
  );

  // -------------------------------------------------------------------- bus
  assign sel_reg  = bus_addr[ADDR_W];
  assign reg_off  = bus_addr[1:0];
  assign wr_reg   = bus_valid && bus_we && sel_reg;
  assign desc_pop = wr_reg && (reg_off == REG_POP) && !desc_empty;
  assign clr_fire = wr_reg && (reg_off == REG_CLR);

  always_comb begin
    reg_rval = '0;
    if (sel_reg && !bus_we) begin
      case (reg_off)
        REG_STATUS: begin
          reg_rval[31:16]          = drop_cnt;
          reg_rval[DESC_DEPTH_W:0] = desc_count;
        end
        REG_DESC: begin
          if (!desc_empty) begin
            reg_rval[16 +: ADDR_W] = head_start;
            reg_rval[0 +: LEN_W]   = head_len;
          end
        end
        default: reg_rval = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_ready_q <= 1'b0;
      sel_ram_q   <= 1'b0;
      reg_rdata_q <= '0;
    end else begin
      bus_ready_q <= bus_valid;
      if (bus_valid) begin
        sel_ram_q   <= !sel_reg && !bus_we;
        reg_rdata_q <= reg_rval;
      end
    end
  end

endmodule
